// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the frisc fetch/next-PC sequencer.
package pc_seq_pkg;
   localparam int XLEN = 32;
   typedef enum logic [2:0] {FETCH, WAIT, ISSUE, EXEC, ADDW, HALTED} state_t;
   typedef enum logic [1:0] {SEQ, IMM, JALR, HALT} kind_t;
   function automatic logic misaligned(input kind_t k, input logic [1:0] lo);
      return (k == IMM || k == JALR) && lo != 2'b00;
   endfunction
endpackage

// File: rtl/pc_seq.sv
// pc_seq: multi-cycle fetch/next-PC sequencer for frisc.
// Optional misaligned-target trap when PC_SEQ_MISALIGN_TRAP_EN is defined.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] pc_cur,
   input  logic            ex_done,
   input  logic [1:0]      ex_kind,
   input  logic [XLEN-1:0] jalr_target,
   input  logic [XLEN-1:0] add4,
   input  logic [XLEN-1:0] addimm,
   output logic            halted,
   output logic [XLEN-1:0] retired
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   ,
   output logic            trap,
   output logic [XLEN-1:0] trap_pc
`endif
);
   state_t          state;
   kind_t           kind;
   logic [XLEN-1:0] pc, target, sel;

   // valids decode the state and are held low while reset is asserted
   assign imem_req_valid = !reset && state == FETCH;
   assign instr_valid    = !reset && state == ISSUE;
   assign imem_req_addr  = pc;
   assign pc_cur         = pc;

   always_comb sel = kind == SEQ ? add4 : kind == IMM ? addimm : target & ~32'h1;

   always_ff @(posedge clk)
      if (reset) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         instr    <= '0;
         instr_pc <= '0;
         retired  <= '0;
         halted   <= 1'b0;
         kind     <= SEQ;
         target   <= '0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
         trap     <= 1'b0;
         trap_pc  <= '0;
`endif
      end else
         case (state)
            FETCH: if (imem_req_ready) state <= WAIT;
            WAIT:
               if (imem_rsp_valid) begin
                  instr    <= imem_rsp_data;
                  instr_pc <= pc;
                  state    <= ISSUE;
               end
            ISSUE: if (instr_ready) state <= EXEC;
            EXEC:
               if (ex_done) begin
                  kind   <= kind_t'(ex_kind);
                  target <= jalr_target;
                  state  <= ADDW;
               end
            ADDW: begin
               retired <= retired + 32'd1;
               if (kind == HALT) begin
                  halted <= 1'b1;
                  state  <= HALTED;
               end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
               else if (misaligned(kind, sel[1:0])) begin
                  trap    <= 1'b1;
                  trap_pc <= sel;
                  halted  <= 1'b1;
                  state   <= HALTED;
               end
`endif
               else begin
                  pc    <= sel & ~32'h3;
                  state <= FETCH;
               end
            end
            HALTED: state <= HALTED;
            default: state <= FETCH;
         endcase
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: randomized scoreboard bench for pc_seq with a peer PC-adder model.
module tb_pc_seq;
   import pc_seq_pkg::*;
   localparam logic [31:0] RPC = 32'h0000_0100;

   logic clk = 0, reset = 1;
   logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
   logic [31:0] imem_req_addr, imem_rsp_data = 0;
   logic instr_valid, instr_ready = 0, ex_done = 0, halted;
   logic [1:0] ex_kind = 0;
   logic [31:0] instr, instr_pc, pc_cur, jalr_target = 0, add4, addimm, retired, imm_in = 0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   logic trap;
   logic [31:0] trap_pc;
`endif

   always #5 clk = ~clk;

   pc_seq #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .pc_cur(pc_cur), .ex_done(ex_done), .ex_kind(ex_kind), .jalr_target(jalr_target),
      .add4(add4), .addimm(addimm), .halted(halted), .retired(retired)
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      , .trap(trap), .trap_pc(trap_pc)
`endif
   );

   // peer PC adder: one-cycle registered pc+4 and pc+imm
   always @(posedge clk) begin
      add4   <= pc_cur + 32'd4;
      addimm <= pc_cur + imm_in;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   logic [31:0] q_addr[$], q_ret[$], q_instr[$], q_ipc[$], q_dg[$], q_de[$];
   string q_dn[$];

   // monitor: all comparisons happen here
   always @(negedge clk) begin : mon
      logic [31:0] a, b, g, e;
      string n;
      if (!reset && imem_req_valid && imem_req_ready) begin
         checks++;
         if (q_addr.size() == 0) begin
            errors++;
            $display("FAIL fetch_unexpected addr=%h", imem_req_addr);
         end else begin
            a = q_addr.pop_front();
            b = q_ret.pop_front();
            if (imem_req_addr !== a || retired !== b) begin
               errors++;
               $display("FAIL fetch got addr=%h retired=%h exp addr=%h retired=%h", imem_req_addr, retired, a, b);
            end
         end
      end
      if (!reset && instr_valid && instr_ready) begin
         checks++;
         if (q_instr.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected instr=%h", instr);
         end else begin
            a = q_instr.pop_front();
            b = q_ipc.pop_front();
            if (instr !== a || instr_pc !== b) begin
               errors++;
               $display("FAIL issue got instr=%h pc=%h exp instr=%h pc=%h", instr, instr_pc, a, b);
            end
         end
      end
      while (q_dn.size() > 0) begin
         n = q_dn.pop_front();
         g = q_dg.pop_front();
         e = q_de.pop_front();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, g, e);
         end
      end
   end

   logic [31:0] m_pc, m_ret, m_tpc;
   logic m_halt, m_trap;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic dchk(input string n, input logic [31:0] g, input logic [31:0] e);
      q_dn.push_back(n);
      q_dg.push_back(g);
      q_de.push_back(e);
   endtask

   task automatic wait_req(output bit ok);
      int n = 0;
      while (!imem_req_valid && n < 100) begin
         tick;
         n++;
      end
      ok = imem_req_valid;
      if (!ok) dchk("req_timeout", 0, 1);
   endtask

   task automatic fetch_phase(input int rd, output bit ok);
      q_addr.push_back(m_pc);
      q_ret.push_back(m_ret);
      wait_req(ok);
      if (!ok) return;
      repeat (rd) begin
         dchk("req_hold_valid", {31'd0, imem_req_valid}, 1);
         dchk("req_hold_addr", imem_req_addr, m_pc);
         tick;
      end
      imem_req_ready = 1;
      tick;
      imem_req_ready = 0;
   endtask

   task automatic back_phase(input kind_t k, input logic [31:0] imm, input logic [31:0] tgt,
                             input int dr, input int di, input int de);
      logic [31:0] d, nxt;
      repeat (dr) begin
         dchk("no_dup_req", {31'd0, imem_req_valid}, 0);
         tick;
      end
      d = $urandom;
      imem_rsp_valid = 1;
      imem_rsp_data  = d;
      q_instr.push_back(d);
      q_ipc.push_back(m_pc);
      tick;
      imem_rsp_valid = 0;
      // stray responses and ex_done pulses must be ignored while issuing
      repeat (di) begin
         imem_rsp_valid = 1;
         imem_rsp_data  = ~d;
         ex_done        = 1;
         ex_kind        = HALT;
         dchk("issue_hold_valid", {31'd0, instr_valid}, 1);
         dchk("issue_hold_instr", instr, d);
         tick;
      end
      imem_rsp_valid = 0;
      ex_done = 0;
      instr_ready = 1;
      tick;
      instr_ready = 0;
      repeat (de) begin
         dchk("exec_no_valid", {31'd0, instr_valid | imem_req_valid}, 0);
         tick;
      end
      ex_done = 1;
      ex_kind = k;
      jalr_target = tgt;
      imm_in = imm;
      tick;
      ex_done = 0;
      ex_kind = 2'($urandom);
      jalr_target = $urandom;
      imm_in = $urandom;
      m_ret = m_ret + 1;
      nxt = k == SEQ ? m_pc + 4 : k == IMM ? m_pc + imm : tgt & ~32'h1;
      if (k == HALT) m_halt = 1;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      else if (nxt[1:0] != 2'b00) begin
         m_halt = 1;
         m_trap = 1;
         m_tpc  = nxt;
      end
`endif
      else m_pc = nxt & ~32'h3;
      tick;
      dchk("retired", retired, m_ret);
      dchk("halted", {31'd0, halted}, {31'd0, m_halt});
   endtask

   task automatic run_instr(input kind_t k, input logic [31:0] imm, input logic [31:0] tgt,
                            input int rd, input int dr, input int di, input int de);
      bit ok;
      fetch_phase(rd, ok);
      if (ok) back_phase(k, imm, tgt, dr, di, de);
   endtask

   task automatic do_reset;
      reset = 1;
      #1;
      dchk("rst_req_valid", {31'd0, imem_req_valid}, 0);
      dchk("rst_instr_valid", {31'd0, instr_valid}, 0);
      tick;
      reset = 0;
      m_pc = RPC;
      m_ret = 0;
      m_halt = 0;
      m_trap = 0;
      m_tpc = 0;
      #1;
      dchk("post_rst_req", {31'd0, imem_req_valid}, 1);
      dchk("post_rst_addr", imem_req_addr, RPC);
      dchk("post_rst_retired", retired, 0);
      dchk("post_rst_halted", {31'd0, halted}, 0);
   endtask

   task automatic halt_idle;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      dchk("trap", {31'd0, trap}, {31'd0, m_trap});
      if (m_trap) dchk("trap_pc", trap_pc, m_tpc);
`endif
      imem_req_ready = 1;
      repeat (20) begin
         dchk("halt_no_req", {31'd0, imem_req_valid | instr_valid}, 0);
         tick;
      end
      imem_req_ready = 0;
      do_reset;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      bit ok;
      kind_t k;
      logic [31:0] imm;
      repeat (3) tick;
      do_reset;
      // straight-line SEQ with zero-wait handshakes: 5 cycles each
      for (int i = 0; i < 3; i++) begin
         t0 = cyc;
         run_instr(SEQ, 0, 0, 0, 0, 0, 0);
         dchk("latency", 32'(cyc - t0), 5);
      end
      dchk("pc_after_seq", pc_cur, 32'h10C);
      run_instr(IMM, 32'h0000_00F4, 0, 0, 0, 0, 0);
      run_instr(IMM, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
      dchk("imm_neg", pc_cur, 32'h1F0);
      run_instr(JALR, 0, 32'h0000_1235, 0, 0, 0, 0);
      dchk("jalr_bit0", pc_cur, 32'h1234);
      run_instr(SEQ, 0, 0, 3, 2, 4, 1);
      run_instr(JALR, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);
      run_instr(SEQ, 0, 0, 0, 0, 0, 0);
      dchk("pc_wrap", pc_cur, 0);
      run_instr(JALR, 0, 32'h0000_0300, 0, 0, 0, 0);
      run_instr(IMM, 32'h0000_0002, 0, 0, 0, 0, 0);
      if (m_halt) halt_idle;
      else dchk("misalign_forced", pc_cur, 32'h300);
      run_instr(HALT, 0, 0, 1, 1, 1, 1);
      halt_idle;
      fetch_phase(0, ok);
      do_reset;
      for (int i = 0; i < 150; i++) begin
         k = kind_t'($urandom_range(0, 2));
         if ($urandom_range(0, 15) == 0) k = HALT;
         imm = $urandom;
         if ($urandom_range(0, 7) != 0) imm = imm & ~32'h3;
         run_instr(k, imm, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
         if (m_halt) halt_idle;
      end
      repeat (3) tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
